// File: rtl/afe_relay_spi_slave_if.sv
// rtl/afe_relay_spi_slave_if.sv - SPI link between the relay master and the relay slave
interface afe_relay_spi_slave_if;
  logic SCLK;
  logic SS_n;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS_n, output MOSI, input MISO);
  modport slave  (input SCLK, input SS_n, input MOSI, output MISO);
endinterface

// File: rtl/afe_relay_spi_slave.sv
// rtl/afe_relay_spi_slave.sv - 24-bit LSB-first SPI slave driving AFE relays with a settle window
// Optional readback of the latched word on MISO: define AFE_RELAY_READBACK_EN.
module afe_relay_spi_slave #(
  parameter int                  DATABITS        = 24,
  parameter int                  SYNC_STAGES     = 2,
  parameter int                  SETTLE_CYCLES   = 250000,
  parameter logic [DATABITS-1:0] RELAY_RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  afe_relay_spi_slave_if.slave        spi,
  output logic [DATABITS-1:0]         relay_out,
  output logic                        relay_valid,
  output logic                        relay_busy,
  output logic [1:0]                  err,
  input  logic                        err_clr
);

  localparam int BC_W = $clog2(DATABITS + 2);
  localparam int SW   = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_hist_q, ss_hist_q;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, ss_fall, ss_rise;

  state_e                 state_q, state_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATABITS-1:0]    shift_in_q, shift_in_d;
  logic [DATABITS-1:0]    relay_out_q, relay_out_d;
  logic                   relay_valid_q, relay_valid_d;
  logic [1:0]             err_q, err_d, err_set;
  logic [SW-1:0]          settle_q, settle_d;
  logic                   pend_q, pend_d;
  logic                   miso_q, miso_d;
  logic                   busy_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ss_hist_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi.SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ss_fall   = ~ss_s & ss_hist_q;
  assign ss_rise   = ss_s & ~ss_hist_q;
  assign busy_w    = (settle_q != '0);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_in_d    = shift_in_q;
    relay_out_d   = relay_out_q;
    relay_valid_d = 1'b0;
    err_set       = 2'b00;
    settle_d      = busy_w ? settle_q - SW'(1) : settle_q;
    // A select fall landing on the LATCH cycle is remembered and served from IDLE next cycle.
    pend_d        = (state_q == LATCH) && ss_fall;
    case (state_q)
      IDLE: begin
        if (ss_fall || pend_q) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          shift_in_d = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          if (bit_cnt_q != BC_W'(DATABITS)) begin
            err_set[0] = 1'b1;
            state_d    = IDLE;
          end else if (busy_w) begin
            err_set[1] = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = LATCH;
          end
        end else if (sclk_rise) begin
          shift_in_d = {mosi_s, shift_in_q[DATABITS-1:1]};
          if (bit_cnt_q != BC_W'(DATABITS + 1)) bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      LATCH: begin
        relay_out_d   = shift_in_q;
        relay_valid_d = 1'b1;
        settle_d      = SW'(SETTLE_CYCLES);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_clr ? 2'b00 : (err_q | err_set);
  end

`ifdef AFE_RELAY_READBACK_EN
  logic                sclk_fall;
  logic [DATABITS-1:0] tx_shift_q, tx_shift_d;

  assign sclk_fall = ~sclk_s & sclk_hist_q;

  always_comb begin
    tx_shift_d = tx_shift_q;
    if (state_q == IDLE && (ss_fall || pend_q))
      tx_shift_d = relay_out_q;
    else if (state_q == SHIFT && !ss_rise && sclk_fall)
      tx_shift_d = {1'b0, tx_shift_q[DATABITS-1:1]};
    miso_d = (state_d == SHIFT) ? tx_shift_d[0] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_shift_q <= '0;
    else          tx_shift_q <= tx_shift_d;
  end
`else
  assign miso_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_in_q    <= '0;
      relay_out_q   <= RELAY_RESET_VAL;
      relay_valid_q <= 1'b0;
      err_q         <= 2'b00;
      settle_q      <= '0;
      pend_q        <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_in_q    <= shift_in_d;
      relay_out_q   <= relay_out_d;
      relay_valid_q <= relay_valid_d;
      err_q         <= err_d;
      settle_q      <= settle_d;
      pend_q        <= pend_d;
      miso_q        <= miso_d;
    end
  end

  assign relay_out   = relay_out_q;
  assign relay_valid = relay_valid_q;
  assign relay_busy  = busy_w;
  assign err         = err_q;
  assign spi.MISO    = miso_q;

endmodule
